// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage RISC-V core: hazard detection,
// stage enables/flushes, EX operand forward selects and stall/flush statistics.
module hazard_controller #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_write_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_dbg_o
);

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [BW-1:0]    r_boot_cnt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Shadow of the instruction in EX (full) and of MEM/WB (only what forwarding needs).
  logic       r_ex_valid, r_ex_use1, r_ex_use2, r_ex_wr, r_ex_ld;
  logic [4:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic       r_mem_valid, r_mem_wr, r_wb_valid, r_wb_wr;
  logic [4:0] r_mem_rd, r_wb_rd;

  logic w_run_go, w_branch, w_hazard, w_load_use, w_bubble;
  logic w_mem_src, w_wb_src;

  assign w_run_go   = (r_state == ST_RUN) && !mem_busy_i;
  assign w_hazard   = r_ex_valid && r_ex_ld && r_ex_wr && (r_ex_rd != 5'd0) && id_valid_i &&
                      ((id_use_rs1_i && (id_rs1_i == r_ex_rd)) ||
                       (id_use_rs2_i && (id_rs2_i == r_ex_rd)));
  assign w_branch   = w_run_go && ex_branch_taken_i;
  assign w_load_use = w_run_go && !ex_branch_taken_i && w_hazard;
  assign w_bubble   = w_branch || w_load_use;

  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    id_ex_write_o  = 1'b0;
    ex_mem_write_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!mem_busy_i) begin
          pc_write_o     = 1'b1;
          if_id_write_o  = 1'b1;
          id_ex_write_o  = 1'b1;
          ex_mem_write_o = 1'b1;
          if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (w_hazard) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: ;
      default: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:     if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
      ST_RUN:      if (mem_busy_i) w_state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!mem_busy_i) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_BOOT;
    endcase
  end

  // MEM wins over WB when both hold the needed register; x0 never forwards.
  assign w_mem_src = r_mem_valid && r_mem_wr && (r_mem_rd != 5'd0);
  assign w_wb_src  = r_wb_valid && r_wb_wr && (r_wb_rd != 5'd0);

  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (r_ex_use1 && w_mem_src && (r_mem_rd == r_ex_rs1))     fwd_a_o = 2'b01;
    else if (r_ex_use1 && w_wb_src && (r_wb_rd == r_ex_rs1))  fwd_a_o = 2'b10;
    if (r_ex_use2 && w_mem_src && (r_mem_rd == r_ex_rs2))     fwd_b_o = 2'b01;
    else if (r_ex_use2 && w_wb_src && (r_wb_rd == r_ex_rs2))  fwd_b_o = 2'b10;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= ST_BOOT;
      r_boot_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_rs1    <= 5'd0;
      r_ex_rs2    <= 5'd0;
      r_ex_use1   <= 1'b0;
      r_ex_use2   <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_ex_wr     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_mem_wr    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_wr     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt + BW'(1);
      if (w_load_use && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_branch && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_run_go) begin
        r_wb_valid  <= r_mem_valid;
        r_wb_rd     <= r_mem_rd;
        r_wb_wr     <= r_mem_wr;
        r_mem_valid <= r_ex_valid;
        r_mem_rd    <= r_ex_rd;
        r_mem_wr    <= r_ex_wr;
        r_ex_valid  <= w_bubble ? 1'b0 : id_valid_i;
        r_ex_rs1    <= w_bubble ? 5'd0 : id_rs1_i;
        r_ex_rs2    <= w_bubble ? 5'd0 : id_rs2_i;
        r_ex_use1   <= w_bubble ? 1'b0 : id_use_rs1_i;
        r_ex_use2   <= w_bubble ? 1'b0 : id_use_rs2_i;
        r_ex_rd     <= w_bubble ? 5'd0 : id_rd_i;
        r_ex_wr     <= w_bubble ? 1'b0 : id_reg_write_i;
        r_ex_ld     <= w_bubble ? 1'b0 : id_mem_read_i;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  assign state_dbg_o = r_state;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with an instruction-level pipeline model
// checked every cycle, plus literal expectations on key cycles.
module tb_hazard_controller;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 16;
  localparam int SAT_W       = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i, id_valid_i, id_use_rs1_i, id_use_rs2_i;
  logic       id_reg_write_i, id_mem_read_i, ex_branch_taken_i, mem_busy_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;

  logic             pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_flush_o, ex_mem_write_o;
  logic [1:0]       fwd_a_o, fwd_b_o, state_dbg_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  logic             s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_write;
  logic [1:0]       s_fwd_a, s_fwd_b, s_state_dbg;
  logic [SAT_W-1:0] s_stall_cnt, s_flush_cnt;

  hazard_controller #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .ex_branch_taken_i(ex_branch_taken_i), .mem_busy_i(mem_busy_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_write_o(id_ex_write_o), .id_ex_flush_o(id_ex_flush_o), .ex_mem_write_o(ex_mem_write_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .state_dbg_o(state_dbg_o)
  );

  hazard_controller #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .ex_branch_taken_i(ex_branch_taken_i), .mem_busy_i(mem_busy_i),
    .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write), .if_id_flush_o(s_if_id_flush),
    .id_ex_write_o(s_id_ex_write), .id_ex_flush_o(s_id_ex_flush), .ex_mem_write_o(s_ex_mem_write),
    .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt),
    .state_dbg_o(s_state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB. phase: 0 warm-up, 1 running, 2 memory outstanding.
  ins_t m_pipe[3];
  int   m_phase, m_boot_seen, m_stalls, m_flushes;

  function automatic ins_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic ld);
    ins_t x;
    x.valid = v; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2; x.rd = rd; x.wr = wr; x.ld = ld;
    return x;
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return mk(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endfunction

  function automatic ins_t load(input logic [4:0] rd, input logic [4:0] rs1);
    return mk(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
  endfunction

  function automatic ins_t nop();
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic bit writes(input ins_t x);
    return x.valid && x.wr && (x.rd != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_it);
    if (!use_it) return 2'b00;
    if (writes(m_pipe[1]) && m_pipe[1].rd == src) return 2'b01;
    if (writes(m_pipe[2]) && m_pipe[2].rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ins_t cur_id();
    return mk(id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i,
              id_reg_write_i, id_mem_read_i);
  endfunction

  function automatic bit load_use();
    ins_t c, e;
    c = cur_id();
    e = m_pipe[0];
    return c.valid && e.valid && e.ld && writes(e) &&
           ((c.u1 && c.rs1 == e.rd) || (c.u2 && c.rs2 == e.rd));
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = nop();
    m_phase = 0; m_boot_seen = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_check();
    logic [5:0] e; // {pc, if_id_w, if_id_fl, id_ex_w, id_ex_fl, ex_mem_w}
    logic [1:0] ea, eb;
    if (m_phase == 0)                   e = 6'b001010;
    else if (m_phase == 2 || mem_busy_i) e = 6'b000000;
    else if (ex_branch_taken_i)          e = 6'b111111;
    else if (load_use())                 e = 6'b000111;
    else                                 e = 6'b110101;
    ea = fwd_sel(m_pipe[0].rs1, m_pipe[0].u1);
    eb = fwd_sel(m_pipe[0].rs2, m_pipe[0].u2);
    chk("ctl", {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o, id_ex_flush_o, ex_mem_write_o}, e);
    chk("fwd_a", fwd_a_o, ea);
    chk("fwd_b", fwd_b_o, eb);
    chk("stall_cnt", stall_cnt_o, sat(m_stalls, CNT_W));
    chk("flush_cnt", flush_cnt_o, sat(m_flushes, CNT_W));
    chk("sat_ctl", {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_write}, e);
    chk("sat_fwd", {s_fwd_a, s_fwd_b}, {ea, eb});
    chk("sat_stall_cnt", s_stall_cnt, sat(m_stalls, SAT_W));
    chk("sat_flush_cnt", s_flush_cnt, sat(m_flushes, SAT_W));
    chk("sat_state_dbg", s_state_dbg, state_dbg_o);
  endtask

  task automatic model_step();
    ins_t nxt;
    bit   lu;
    case (m_phase)
      0: begin
        m_boot_seen++;
        if (m_boot_seen >= BOOT_CYCLES) m_phase = 1;
      end
      2: if (!mem_busy_i) m_phase = 1;
      default: begin
        if (mem_busy_i) m_phase = 2;
        else begin
          lu  = load_use();
          nxt = cur_id();
          if (ex_branch_taken_i) begin m_flushes++; nxt = nop(); end
          else if (lu)           begin m_stalls++;  nxt = nop(); end
          m_pipe[2] = m_pipe[1];
          m_pipe[1] = m_pipe[0];
          m_pipe[0] = nxt;
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_i) model_reset();
      model_check();
      if (reset_i) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input ins_t x, input logic br, input logic busy);
    id_valid_i = x.valid; id_rs1_i = x.rs1; id_rs2_i = x.rs2;
    id_use_rs1_i = x.u1; id_use_rs2_i = x.u2; id_rd_i = x.rd;
    id_reg_write_i = x.wr; id_mem_read_i = x.ld;
    ex_branch_taken_i = br; mem_busy_i = busy;
  endtask

  task automatic cyc(input ins_t x, input logic br = 1'b0, input logic busy = 1'b0);
    @(posedge clk); #1;
    put(x, br, busy);
    @(negedge clk);
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk); #1;
    reset_i = v;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, pc_write_o, 1'b0);
    chk({tag, "_en"}, {if_id_write_o, id_ex_write_o, ex_mem_write_o}, 3'b000);
    chk({tag, "_flush"}, {if_id_flush_o, id_ex_flush_o}, 2'b11);
    chk({tag, "_fwd"}, {fwd_a_o, fwd_b_o}, 4'b0000);
    chk({tag, "_cnt"}, {stall_cnt_o, flush_cnt_o}, 32'd0);
  endtask

  task automatic boot_sequence(input string tag);
    set_reset(1'b1);
    chk({tag, "_boot1_pc"}, pc_write_o, 1'b0);
    cyc(nop());
    chk({tag, "_boot2_pc"}, pc_write_o, 1'b0);
    chk({tag, "_boot2_flush"}, {if_id_flush_o, id_ex_flush_o}, 2'b11);
    cyc(nop());
    chk({tag, "_run_pc"}, pc_write_o, 1'b1);
    chk({tag, "_run_flush"}, {if_id_flush_o, id_ex_flush_o}, 2'b00);
  endtask

  // ---------------- directed stimulus ----------------
  logic [1:0] boot_code, run_code;

  initial begin
    reset_i = 1'b0;
    put(nop(), 1'b0, 1'b0);
    @(negedge clk);
    check_reset_values("rst0");
    boot_code = state_dbg_o;
    boot_sequence("b0");
    run_code = state_dbg_o;
    chk("dbg_run_ne_boot", {31'd0, run_code != boot_code}, 32'd1);

    // lw x5 ; add x6,x5,x7
    cyc(load(5'd5, 5'd1));
    cyc(alu(5'd6, 5'd5, 5'd7));
    chk("lu_ctl", {pc_write_o, if_id_write_o, id_ex_flush_o, id_ex_write_o}, 4'b0011);
    cyc(alu(5'd6, 5'd5, 5'd7));
    chk("lu_stall_cnt", stall_cnt_o, 16'd1);
    chk("lu_resume_pc", pc_write_o, 1'b1);
    cyc(nop());
    chk("lu_fwd", {fwd_a_o, fwd_b_o}, 4'b1000);

    // add x5,x1,x2 ; sub x8,x5,x5
    cyc(alu(5'd5, 5'd1, 5'd2));
    cyc(alu(5'd8, 5'd5, 5'd5));
    chk("alu_nostall_pc", pc_write_o, 1'b1);
    cyc(nop());
    chk("alu_fwd", {fwd_a_o, fwd_b_o}, 4'b0101);

    // x0 never forwards, load to x0 never stalls
    cyc(alu(5'd0, 5'd1, 5'd2));
    cyc(alu(5'd3, 5'd0, 5'd0));
    cyc(nop());
    chk("x0_fwd", {fwd_a_o, fwd_b_o}, 4'b0000);
    cyc(load(5'd0, 5'd1));
    cyc(alu(5'd4, 5'd0, 5'd0));
    chk("x0_load_nostall", pc_write_o, 1'b1);
    cyc(nop());

    // branch taken together with a load-use hazard
    cyc(load(5'd9, 5'd1));
    cyc(alu(5'd10, 5'd9, 5'd9), 1'b1);
    chk("br_ctl", {pc_write_o, if_id_flush_o, id_ex_flush_o}, 3'b111);
    cyc(nop());
    chk("br_cnts", {stall_cnt_o, flush_cnt_o}, {16'd1, 16'd1});

    // memory busy for 3 cycles -> 4 frozen cycles with stable forwarding
    cyc(alu(5'd11, 5'd1, 5'd2));
    cyc(alu(5'd12, 5'd11, 5'd3));
    cyc(nop(), 1'b0, 1'b1);
    chk("mb1_ctl", {pc_write_o, ex_mem_write_o, fwd_a_o}, 4'b0001);
    cyc(nop(), 1'b1, 1'b1);
    chk("mb2_ctl", {pc_write_o, if_id_flush_o, fwd_a_o}, 4'b0001);
    chk("mb_dbg_ne_run", {31'd0, state_dbg_o != run_code}, 32'd1);
    cyc(nop(), 1'b0, 1'b1);
    chk("mb3_pc", pc_write_o, 1'b0);
    cyc(nop());
    chk("mb_recover_ctl", {pc_write_o, ex_mem_write_o, fwd_a_o}, 4'b0001);
    cyc(nop());
    chk("mb_after_ctl", {pc_write_o, fwd_a_o}, 3'b101);
    chk("mb_flush_cnt", flush_cnt_o, 16'd1);

    // five more load-use stalls: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      cyc(load(5'd5, 5'd1));
      cyc(alu(5'd6, 5'd5, 5'd5));
      cyc(alu(5'd6, 5'd5, 5'd5));
    end
    cyc(nop());
    chk("sat_stall_wide", stall_cnt_o, 16'd6);
    chk("sat_stall_narrow", s_stall_cnt, 2'd3);

    // reset in the middle of a memory wait
    cyc(nop(), 1'b0, 1'b1);
    cyc(nop(), 1'b0, 1'b1);
    set_reset(1'b0);
    check_reset_values("rst_mw");
    put(nop(), 1'b0, 1'b0);
    boot_sequence("b1");

    // reset in the middle of a load-use stall
    cyc(load(5'd7, 5'd2));
    cyc(alu(5'd8, 5'd7, 5'd1));
    chk("lu2_pc", pc_write_o, 1'b0);
    set_reset(1'b0);
    check_reset_values("rst_lu");
    put(nop(), 1'b0, 1'b0);
    boot_sequence("b2");
    cyc(alu(5'd13, 5'd1, 5'd2));
    cyc(nop());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
